// File: rtl/commit_buffer_if.sv
`default_nettype none
// ============================================================================
// commit_buffer_if : dispatch / completion / retire bundle for commit_buffer.
// Optional stats fields present when COMMIT_BUFFER_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
interface commit_buffer_if;
  logic        alloc_en;
  logic        alloc_reject;
  logic [7:0]  alloc_commit_id;

  logic        result_en;
  logic [7:0]  result_commit_id;
  logic        result_kind;
  logic [7:0]  result_dest_logic;
  logic [31:0] result_data;
  logic        result_miss;
  logic        result_taken;
  logic [15:0] result_new_pc;

  logic        commit_en;
  logic [7:0]  commit_dest_logic;
  logic [31:0] commit_data;
  logic        branch_en;
  logic        branch_miss;
  logic        branch_taken;
  logic [15:0] branch_new_pc;
  logic        flush;
`ifdef COMMIT_BUFFER_STATS_EN
  logic [31:0] stat_commits;
  logic [31:0] stat_misses;
`endif

  modport master (
    output alloc_en, result_en, result_commit_id, result_kind, result_dest_logic,
           result_data, result_miss, result_taken, result_new_pc,
    input  alloc_reject, alloc_commit_id, commit_en, commit_dest_logic, commit_data,
           branch_en, branch_miss, branch_taken, branch_new_pc, flush
`ifdef COMMIT_BUFFER_STATS_EN
    , input stat_commits, stat_misses
`endif
  );

  modport slave (
    input  alloc_en, result_en, result_commit_id, result_kind, result_dest_logic,
           result_data, result_miss, result_taken, result_new_pc,
    output alloc_reject, alloc_commit_id, commit_en, commit_dest_logic, commit_data,
           branch_en, branch_miss, branch_taken, branch_new_pc, flush
`ifdef COMMIT_BUFFER_STATS_EN
    , output stat_commits, stat_misses
`endif
  );
endinterface
`default_nettype wire

// File: rtl/commit_buffer.sv
`default_nettype none
// ============================================================================
// commit_buffer : in-order reorder buffer, one retire per cycle, squash on miss.
// Optional macro COMMIT_BUFFER_STATS_EN adds retire / flush counters.
// Revision: 1.0
// ============================================================================
module commit_buffer #(
  parameter int DEPTH = 64,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           reset,
  commit_buffer_if.slave bus
);
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_kind;
  logic [DEPTH-1:0] r_miss;
  logic [DEPTH-1:0] r_taken;
  logic [7:0]       r_dest   [DEPTH];
  logic [31:0]      r_data   [DEPTH];
  logic [15:0]      r_new_pc [DEPTH];

  logic        r_commit_en;
  logic [7:0]  r_commit_dest;
  logic [31:0] r_commit_data;
  logic        r_branch_en;
  logic        r_branch_miss;
  logic        r_branch_taken;
  logic [15:0] r_branch_new_pc;
  logic        r_flush;

  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic [PTR_W-1:0] w_ptr_one;
  logic             w_full;
  logic             w_ready;
  logic             w_flush_pending;
  logic             w_reject;
  logic             w_alloc;
  logic             w_result;
  logic             w_unused;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_res_idx  = bus.result_commit_id[IDX_W-1:0];
  assign w_ptr_one  = {{(PTR_W-1){1'b0}}, 1'b1};
  assign w_unused   = &{1'b0, bus.result_commit_id[7:IDX_W]};

  assign w_full          = (w_head_idx == w_tail_idx) && (r_head[PTR_W-1] != r_tail[PTR_W-1]);
  assign w_ready         = r_valid[w_head_idx] & r_done[w_head_idx];
  assign w_flush_pending = w_ready & r_kind[w_head_idx] & r_miss[w_head_idx];
  assign w_reject        = w_full | w_flush_pending;
  assign w_alloc         = bus.alloc_en & ~w_reject;
  // Results to unallocated slots, or arriving on the squash edge, are dropped.
  assign w_result        = bus.result_en & r_valid[w_res_idx] & ~w_flush_pending;

  assign bus.alloc_reject    = w_reject;
  assign bus.alloc_commit_id = 8'(w_tail_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else if (w_flush_pending) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_alloc) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_tail              <= r_tail + w_ptr_one;
      end
      if (w_result) begin
        r_done[w_res_idx] <= 1'b1;
      end
      // Retire is last so it wins over a late result to the same slot.
      if (w_ready) begin
        r_valid[w_head_idx] <= 1'b0;
        r_done[w_head_idx]  <= 1'b0;
        r_head              <= r_head + w_ptr_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_result) begin
      r_kind[w_res_idx]   <= bus.result_kind;
      r_miss[w_res_idx]   <= bus.result_miss;
      r_taken[w_res_idx]  <= bus.result_taken;
      r_dest[w_res_idx]   <= bus.result_dest_logic;
      r_data[w_res_idx]   <= bus.result_data;
      r_new_pc[w_res_idx] <= bus.result_new_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_commit_en     <= 1'b0;
      r_commit_dest   <= '0;
      r_commit_data   <= '0;
      r_branch_en     <= 1'b0;
      r_branch_miss   <= 1'b0;
      r_branch_taken  <= 1'b0;
      r_branch_new_pc <= '0;
      r_flush         <= 1'b0;
    end else begin
      r_commit_en <= w_ready & ~r_kind[w_head_idx];
      r_branch_en <= w_ready & r_kind[w_head_idx];
      r_flush     <= w_flush_pending;
      if (w_ready && !r_kind[w_head_idx]) begin
        r_commit_dest <= r_dest[w_head_idx];
        r_commit_data <= r_data[w_head_idx];
      end
      if (w_ready && r_kind[w_head_idx]) begin
        r_branch_miss   <= r_miss[w_head_idx];
        r_branch_taken  <= r_taken[w_head_idx];
        r_branch_new_pc <= r_new_pc[w_head_idx];
      end
    end
  end

  assign bus.commit_en         = r_commit_en;
  assign bus.commit_dest_logic = r_commit_dest;
  assign bus.commit_data       = r_commit_data;
  assign bus.branch_en         = r_branch_en;
  assign bus.branch_miss       = r_branch_miss;
  assign bus.branch_taken      = r_branch_taken;
  assign bus.branch_new_pc     = r_branch_new_pc;
  assign bus.flush             = r_flush;

`ifdef COMMIT_BUFFER_STATS_EN
  logic [31:0] r_stat_commits;
  logic [31:0] r_stat_misses;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_commits <= '0;
      r_stat_misses  <= '0;
    end else begin
      if (w_ready)         r_stat_commits <= r_stat_commits + 32'd1;
      if (w_flush_pending) r_stat_misses  <= r_stat_misses + 32'd1;
    end
  end

  assign bus.stat_commits = r_stat_commits;
  assign bus.stat_misses  = r_stat_misses;
`endif
endmodule
`default_nettype wire

// File: tb/tb_commit_buffer.sv
`default_nettype none
// tb_commit_buffer : scoreboard bench; a program-order model pushes expected
// retirements, a negedge monitor pops and compares them.
module tb_commit_buffer;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  commit_buffer_if bus();

  commit_buffer #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        kind;
    logic [7:0]  dest;
    logic [31:0] data;
    logic        miss;
    logic        taken;
    logic [15:0] pc;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_pay[DEPTH];
  logic m_valid[DEPTH];
  logic m_done[DEPTH];
  int   m_head, m_tail;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
    m_head = 0;
    m_tail = 0;
  endfunction

  function automatic void model_alloc();
    m_valid[m_tail] = 1'b1;
    m_done[m_tail]  = 1'b0;
    m_tail = (m_tail + 1) % DEPTH;
  endfunction

  // Retires every completed entry at the head in program order.
  function automatic void model_result(input int id, input exp_t p);
    if (!m_valid[id]) return;
    m_pay[id]  = p;
    m_done[id] = 1'b1;
    while (m_valid[m_head] && m_done[m_head]) begin
      sb_q.push_back(m_pay[m_head]);
      m_valid[m_head] = 1'b0;
      m_done[m_head]  = 1'b0;
      if (m_pay[m_head].kind && m_pay[m_head].miss) begin
        model_reset();
        break;
      end
      m_head = (m_head + 1) % DEPTH;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (bus.commit_en || bus.branch_en || bus.flush)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_retire", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("retire_kind", {bus.commit_en, bus.branch_en}, {~e.kind, e.kind});
        if (!e.kind) begin
          check("commit_dest", bus.commit_dest_logic, e.dest);
          check("commit_data", bus.commit_data, e.data);
        end else begin
          check("branch_miss", bus.branch_miss, e.miss);
          check("branch_taken", bus.branch_taken, e.taken);
          check("branch_new_pc", bus.branch_new_pc, e.pc);
        end
        check("flush", bus.flush, e.kind & e.miss);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_en          = 1'b0;
    bus.result_en         = 1'b0;
    bus.result_commit_id  = '0;
    bus.result_kind       = 1'b0;
    bus.result_dest_logic = '0;
    bus.result_data       = '0;
    bus.result_miss       = 1'b0;
    bus.result_taken      = 1'b0;
    bus.result_new_pc     = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  task automatic do_alloc();
    bus.alloc_en = 1'b1;
    check("alloc_reject", bus.alloc_reject, 0);
    check("alloc_id", bus.alloc_commit_id, m_tail);
    step();
    bus.alloc_en = 1'b0;
    model_alloc();
  endtask

  task automatic do_result(input int id, input exp_t p);
    bus.result_en         = 1'b1;
    bus.result_commit_id  = 8'(id);
    bus.result_kind       = p.kind;
    bus.result_dest_logic = p.dest;
    bus.result_data       = p.data;
    bus.result_miss       = p.miss;
    bus.result_taken      = p.taken;
    bus.result_new_pc     = p.pc;
    step();
    bus.result_en = 1'b0;
    model_result(id, p);
  endtask

  function automatic exp_t wb(input logic [7:0] d, input logic [31:0] v);
    wb = '{kind: 1'b0, dest: d, data: v, miss: 1'b0, taken: 1'b0, pc: 16'h0};
  endfunction

  function automatic exp_t br(input logic m, input logic t, input logic [15:0] pc);
    br = '{kind: 1'b1, dest: 8'h0, data: 32'h0, miss: m, taken: t, pc: pc};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_commit_en"}, bus.commit_en, 0);
    check({tag, "_branch_en"}, bus.branch_en, 0);
    check({tag, "_flush"}, bus.flush, 0);
    check({tag, "_data"}, {bus.commit_dest_logic, bus.commit_data}, 0);
    check({tag, "_branch"}, {bus.branch_miss, bus.branch_taken, bus.branch_new_pc}, 0);
    check({tag, "_alloc_id"}, bus.alloc_commit_id, 0);
    check({tag, "_alloc_reject"}, bus.alloc_reject, 0);
  endtask

  initial begin
    #2_000_000;
    check("timeout", 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int ids[16];
    int tmp, j;
    idle_inputs();
    do_reset();
    check_reset_outputs("rst");

    // In-order retirement of out-of-order completions, with latency.
    for (int i = 0; i < 3; i++) do_alloc();
    do_result(2, wb(8'd5, 32'hA));
    do_result(0, wb(8'd6, 32'hB));
    check("lat_not_yet", bus.commit_en, 0);
    do_result(1, wb(8'd7, 32'hC));
    check("lat_id0", bus.commit_en, 1);
    step();
    check("b2b_id1", bus.commit_en, 1);
    step();
    check("b2b_id2", bus.commit_en, 1);
    step();
    check("b2b_idle", bus.commit_en, 0);
    check("s1_drained", sb_q.size(), 0);

    // Full, then wrap of the tail pointer.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_alloc();
    bus.alloc_en = 1'b1;
    check("full_reject", bus.alloc_reject, 1);
    step();
    check("full_still", bus.alloc_reject, 1);
    bus.alloc_en = 1'b0;
    do_result(0, wb(8'h11, 32'h1234));
    check("full_until_retire", bus.alloc_reject, 1);
    step();
    check("free_after_retire", bus.alloc_reject, 0);
    do_alloc();
    check("full_after_wrap", bus.alloc_reject, 1);
    step();
    check("s2_drained", sb_q.size(), 0);

    // Mispredicted branch squashes younger entries.
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc();
    do_result(1, br(1'b1, 1'b1, 16'h0040));
    do_result(0, wb(8'd3, 32'h5555));
    do_result(2, wb(8'd4, 32'h6666));
    check("flush_pending_reject", bus.alloc_reject, 1);
    do_result(3, wb(8'd8, 32'h7777));
    check("flush_pulse", bus.flush, 1);
    check("flush_pc", bus.branch_new_pc, 16'h0040);
    step();
    check("flush_one_cycle", bus.flush, 0);
    step();
    step();
    check("s3_drained", sb_q.size(), 0);
`ifdef COMMIT_BUFFER_STATS_EN
    check("stat_commits", bus.stat_commits, 2);
    check("stat_misses", bus.stat_misses, 1);
`endif
    do_alloc();

    // Result to an unallocated slot is dropped.
    do_result(9, wb(8'h99, 32'h9999));
    for (int i = 0; i < 3; i++) begin
      check("drop_no_commit", bus.commit_en, 0);
      step();
    end
    do_alloc();
    do_result(1, wb(8'd21, 32'h2121));
    do_result(0, wb(8'd20, 32'h2020));
    step();
    step();
    step();
    check("s4_drained", sb_q.size(), 0);

    // Random completion order with non-miss branches mixed in.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_alloc();
      ids[i] = i;
    end
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = ids[i];
      ids[i] = ids[j];
      ids[j] = tmp;
    end
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(3, 0) == 0)
        do_result(ids[i], br(1'b0, 1'($urandom), 16'($urandom)));
      else
        do_result(ids[i], wb(8'($urandom), $urandom));
    end
    for (int i = 0; i < 20; i++) step();
    check("rand_drained", sb_q.size(), 0);

    // Reset in the middle of activity.
    do_reset();
    for (int i = 0; i < 10; i++) do_alloc();
    for (int i = 0; i < 3; i++) do_result(i, wb(8'(30 + i), 32'h1000 + 32'(i)));
    check("busy_before_reset", bus.commit_en, 1);
    reset = 1'b1;
    step();
    check_reset_outputs("midrst");
    model_reset();
    sb_q.delete();
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
